// File: rtl/elevator_car_ctrl_if.sv
// rtl/elevator_car_ctrl_if.sv - request/clear bundle between the floor-request latch and the car controller
interface elevator_car_ctrl_if #(
    parameter int BUTTONS_WIDTH = 8
);
    logic [BUTTONS_WIDTH-1:0] active_in_levels;
    logic [BUTTONS_WIDTH-1:0] active_out_up_levels;
    logic [BUTTONS_WIDTH-1:0] active_out_down_levels;
    logic [BUTTONS_WIDTH-1:0] clr_in_levels;
    logic [BUTTONS_WIDTH-1:0] clr_out_up_levels;
    logic [BUTTONS_WIDTH-1:0] clr_out_down_levels;

    modport master (
        output active_in_levels, active_out_up_levels, active_out_down_levels,
        input  clr_in_levels, clr_out_up_levels, clr_out_down_levels
    );

    modport slave (
        input  active_in_levels, active_out_up_levels, active_out_down_levels,
        output clr_in_levels, clr_out_up_levels, clr_out_down_levels
    );
endinterface

// File: rtl/elevator_car_ctrl.sv
// rtl/elevator_car_ctrl.sv - collective up/down (SCAN) car controller with door timing and request clear pulses
module elevator_car_ctrl #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int LEVEL_WIDTH   = 3,
    parameter int MOVE_CYCLES   = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    elevator_car_ctrl_if.slave     req_if,
    output logic [LEVEL_WIDTH-1:0] current_level,
    output logic                   moving_up,
    output logic                   moving_down,
    output logic                   door_open,
    output logic                   dir_up
);
    localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        ARRIVE,
        DOOR_OPEN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic [BUTTONS_WIDTH-1:0] req, at_f, above_mask, below_mask;
    logic above, below, ahead, behind;
    logic in_f, up_f, dn_f, take_up, take_dn, stop, turn;
    logic [BUTTONS_WIDTH-1:0] re_in, re_hall;

    always_comb begin
        at_f       = '0;
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < BUTTONS_WIDTH; i++) begin
            at_f[i]       = (current_level == LEVEL_WIDTH'(i));
            above_mask[i] = (LEVEL_WIDTH'(i) > current_level);
            below_mask[i] = (LEVEL_WIDTH'(i) < current_level);
        end
        req    = req_if.active_in_levels | req_if.active_out_up_levels | req_if.active_out_down_levels;
        above  = |(req & above_mask);
        below  = |(req & below_mask);
        ahead  = dir_up ? above : below;
        behind = dir_up ? below : above;
        in_f   = |(req_if.active_in_levels & at_f);
        up_f   = |(req_if.active_out_up_levels & at_f);
        dn_f   = |(req_if.active_out_down_levels & at_f);
        // An opposite-direction hall call is only taken when nothing remains ahead, i.e. the car turns here.
        take_up = up_f & (dir_up | ~ahead);
        take_dn = dn_f & (~dir_up | ~ahead);
        stop    = in_f | take_up | take_dn;
        turn    = dir_up ? take_dn : take_up;
        // Re-arrivals during the door window; bits still being cleared this cycle are not counted again.
        re_in   = req_if.active_in_levels & at_f & ~req_if.clr_in_levels;
        re_hall = dir_up ? (req_if.active_out_up_levels & at_f & ~req_if.clr_out_up_levels)
                         : (req_if.active_out_down_levels & at_f & ~req_if.clr_out_down_levels);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                     <= IDLE;
            cnt                       <= '0;
            current_level             <= '0;
            dir_up                    <= 1'b1;
            moving_up                 <= 1'b0;
            moving_down               <= 1'b0;
            door_open                 <= 1'b0;
            req_if.clr_in_levels      <= '0;
            req_if.clr_out_up_levels  <= '0;
            req_if.clr_out_down_levels <= '0;
        end else begin
            req_if.clr_in_levels       <= '0;
            req_if.clr_out_up_levels   <= '0;
            req_if.clr_out_down_levels <= '0;
            case (state)
                IDLE, ARRIVE: begin
                    cnt <= '0;
                    if (stop) begin
                        state                      <= DOOR_OPEN;
                        door_open                  <= 1'b1;
                        req_if.clr_in_levels       <= req_if.active_in_levels & at_f;
                        req_if.clr_out_up_levels   <= take_up ? at_f : '0;
                        req_if.clr_out_down_levels <= take_dn ? at_f : '0;
                        if (state == ARRIVE && turn)
                            dir_up <= ~dir_up;
                    end else if (ahead) begin
                        state       <= dir_up ? MOVE_UP : MOVE_DOWN;
                        moving_up   <= dir_up;
                        moving_down <= ~dir_up;
                    end else if (behind && state == IDLE) begin
                        dir_up      <= ~dir_up;
                        state       <= dir_up ? MOVE_DOWN : MOVE_UP;
                        moving_up   <= ~dir_up;
                        moving_down <= dir_up;
                    end else begin
                        state <= IDLE;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (cnt == CW'(MOVE_CYCLES - 1)) begin
                        state         <= ARRIVE;
                        cnt           <= '0;
                        moving_up     <= 1'b0;
                        moving_down   <= 1'b0;
                        current_level <= (state == MOVE_UP) ? current_level + 1'b1
                                                            : current_level - 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DOOR_OPEN: begin
                    if ((|re_in) || (|re_hall)) begin
                        cnt                  <= '0;
                        req_if.clr_in_levels <= re_in;
                        if (dir_up)
                            req_if.clr_out_up_levels <= re_hall;
                        else
                            req_if.clr_out_down_levels <= re_hall;
                    end else if (cnt == CW'(DOOR_CYCLES - 1)) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        door_open <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    moving_up   <= 1'b0;
                    moving_down <= 1'b0;
                    door_open   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb/tb_elevator_car_ctrl.sv - scoreboard bench for elevator_car_ctrl
module tb_elevator_car_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] current_level;
    logic       moving_up, moving_down, door_open, dir_up;

    always #5 clk = ~clk;

    elevator_car_ctrl_if #(.BUTTONS_WIDTH(8)) ifc ();

    elevator_car_ctrl #(
        .BUTTONS_WIDTH(8),
        .LEVEL_WIDTH(3),
        .MOVE_CYCLES(4),
        .DOOR_CYCLES(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_if(ifc),
        .current_level(current_level),
        .moving_up(moving_up),
        .moving_down(moving_down),
        .door_open(door_open),
        .dir_up(dir_up)
    );

    typedef struct {
        logic [2:0] lvl;
        logic [7:0] ci;
        logic [7:0] cu;
        logic [7:0] cd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input logic [2:0] l, input logic [7:0] ci, input logic [7:0] cu, input logic [7:0] cd);
        exp_t e;
        e.lvl = l; e.ci = ci; e.cu = cu; e.cd = cd;
        return e;
    endfunction

    // Clear-pulse scoreboard plus a behavioural request latch
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if ((ifc.clr_in_levels | ifc.clr_out_up_levels | ifc.clr_out_down_levels) != 8'h00) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL clr_unexpected lvl=%0d in=%h up=%h dn=%h required no pulse",
                             current_level, ifc.clr_in_levels, ifc.clr_out_up_levels, ifc.clr_out_down_levels);
                end else begin
                    e = exp_q.pop_front();
                    if ({current_level, ifc.clr_in_levels, ifc.clr_out_up_levels, ifc.clr_out_down_levels}
                        !== {e.lvl, e.ci, e.cu, e.cd}) begin
                        bad++;
                        $display("FAIL clr_pulse got lvl=%0d in=%h up=%h dn=%h required lvl=%0d in=%h up=%h dn=%h",
                                 current_level, ifc.clr_in_levels, ifc.clr_out_up_levels, ifc.clr_out_down_levels,
                                 e.lvl, e.ci, e.cu, e.cd);
                    end
                end
                total++;
                if (door_open !== 1'b1) begin
                    bad++;
                    $display("FAIL clr_outside_door door_open=%b required 1", door_open);
                end
            end
            total++;
            if ((int'(moving_up) + int'(moving_down) + int'(door_open)) > 1) begin
                bad++;
                $display("FAIL exclusive mu=%b md=%b door=%b required at most one", moving_up, moving_down, door_open);
            end
            ifc.active_in_levels       &= ~ifc.clr_in_levels;
            ifc.active_out_up_levels   &= ~ifc.clr_out_up_levels;
            ifc.active_out_down_levels &= ~ifc.clr_out_down_levels;
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        ifc.active_in_levels       = 8'h00;
        ifc.active_out_up_levels   = 8'h00;
        ifc.active_out_down_levels = 8'h00;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && !door_open && !moving_up && !moving_down) && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL %s timeout pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        ifc.active_in_levels = 8'h80;
        for (n = 0; n < 100 && !(current_level == 3'd2 && moving_up); n++) @(negedge clk);
        total++;
        if (!(current_level == 3'd2 && moving_up)) begin
            bad++;
            $display("FAIL reset_reach_transit lvl=%0d mu=%b required lvl=2 mu=1", current_level, moving_up);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({current_level, moving_up, moving_down, door_open, dir_up} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_async lvl=%0d mu=%b md=%b door=%b dir=%b required 0 0 0 0 1",
                     current_level, moving_up, moving_down, door_open, dir_up);
        end
        total++;
        if ((ifc.clr_in_levels | ifc.clr_out_up_levels | ifc.clr_out_down_levels) !== 8'h00) begin
            bad++;
            $display("FAIL reset_clr got %h required 00",
                     ifc.clr_in_levels | ifc.clr_out_up_levels | ifc.clr_out_down_levels);
        end
        ifc.active_in_levels = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if ({current_level, moving_up, moving_down, door_open, dir_up} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_idle lvl=%0d mu=%b md=%b door=%b dir=%b required 0 0 0 0 1",
                     current_level, moving_up, moving_down, door_open, dir_up);
        end
    endtask

    task automatic test_single_trip();
        logic       e_mu, e_door;
        logic [2:0] e_lvl;
        do_reset();
        ifc.active_in_levels = 8'h02;
        exp_q.push_back(mk(3'd1, 8'h02, 8'h00, 8'h00));
        for (int n = 0; n <= 12; n++) begin
            if (n > 0) @(negedge clk);
            else #1;
            e_mu   = (n >= 1 && n <= 4);
            e_door = (n >= 6 && n <= 11);
            e_lvl  = (n >= 5) ? 3'd1 : 3'd0;
            total++;
            if ({moving_up, moving_down, door_open, current_level} !== {e_mu, 1'b0, e_door, e_lvl}) begin
                bad++;
                $display("FAIL single_trip step=%0d mu=%b md=%b door=%b lvl=%0d required mu=%b md=0 door=%b lvl=%0d",
                         n, moving_up, moving_down, door_open, current_level, e_mu, e_door, e_lvl);
            end
            if (n == 7) begin
                total++;
                if (ifc.clr_in_levels !== 8'h00) begin
                    bad++;
                    $display("FAIL single_clr_once step=7 clr_in=%h required 00", ifc.clr_in_levels);
                end
            end
        end
    endtask

    task automatic test_sweep_up();
        do_reset();
        ifc.active_out_up_levels   = 8'h30;
        ifc.active_out_down_levels = 8'h80;
        exp_q.push_back(mk(3'd4, 8'h00, 8'h10, 8'h00));
        exp_q.push_back(mk(3'd5, 8'h00, 8'h20, 8'h00));
        exp_q.push_back(mk(3'd7, 8'h00, 8'h00, 8'h80));
        drain("sweep_up", 400);
        total++;
        if ({current_level, dir_up} !== {3'd7, 1'b0}) begin
            bad++;
            $display("FAIL sweep_end lvl=%0d dir=%b required lvl=7 dir=0", current_level, dir_up);
        end
    endtask

    task automatic test_reverse();
        int n;
        do_reset();
        ifc.active_in_levels = 8'h20;
        exp_q.push_back(mk(3'd5, 8'h20, 8'h00, 8'h00));
        drain("reverse_setup", 200);
        ifc.active_out_down_levels = 8'h40;
        ifc.active_out_up_levels   = 8'h04;
        exp_q.push_back(mk(3'd6, 8'h00, 8'h00, 8'h40));
        exp_q.push_back(mk(3'd2, 8'h00, 8'h04, 8'h00));
        for (n = 0; n < 100 && !(door_open && current_level == 3'd6); n++) @(negedge clk);
        total++;
        if ({door_open, current_level, dir_up} !== {1'b1, 3'd6, 1'b0}) begin
            bad++;
            $display("FAIL reverse_turn door=%b lvl=%0d dir=%b required door=1 lvl=6 dir=0",
                     door_open, current_level, dir_up);
        end
        drain("reverse", 300);
        total++;
        if ({current_level, dir_up} !== {3'd2, 1'b1}) begin
            bad++;
            $display("FAIL reverse_end lvl=%0d dir=%b required lvl=2 dir=1", current_level, dir_up);
        end
    endtask

    task automatic test_door_extend();
        int n;
        logic       e_door;
        logic [7:0] e_clr;
        do_reset();
        ifc.active_in_levels = 8'h08;
        exp_q.push_back(mk(3'd3, 8'h08, 8'h00, 8'h00));
        for (n = 0; n < 100 && !door_open; n++) @(negedge clk);
        for (int c = 1; c <= 11; c++) begin
            e_door = (c <= 10);
            e_clr  = (c == 1 || c == 5) ? 8'h08 : 8'h00;
            total++;
            if ({door_open, ifc.clr_in_levels, current_level} !== {e_door, e_clr, 3'd3}) begin
                bad++;
                $display("FAIL door_extend cycle=%0d door=%b clr_in=%h lvl=%0d required door=%b clr_in=%h lvl=3",
                         c, door_open, ifc.clr_in_levels, current_level, e_door, e_clr);
            end
            if (c == 4) begin
                ifc.active_in_levels |= 8'h08;
                exp_q.push_back(mk(3'd3, 8'h08, 8'h00, 8'h00));
            end
            @(negedge clk);
        end
        drain("door_extend", 50);
    endtask

    task automatic test_opposite_hold();
        int n;
        do_reset();
        ifc.active_in_levels = 8'h88;
        exp_q.push_back(mk(3'd3, 8'h08, 8'h00, 8'h00));
        for (n = 0; n < 100 && !door_open; n++) @(negedge clk);
        @(negedge clk);
        ifc.active_out_down_levels |= 8'h08;
        for (n = 0; n < 100 && !(moving_up || moving_down); n++) @(negedge clk);
        total++;
        if ({moving_up, moving_down, current_level, ifc.active_out_down_levels[3]} !== {1'b1, 1'b0, 3'd3, 1'b1}) begin
            bad++;
            $display("FAIL opposite_hold mu=%b md=%b lvl=%0d down3=%b required mu=1 md=0 lvl=3 down3=1",
                     moving_up, moving_down, current_level, ifc.active_out_down_levels[3]);
        end
        exp_q.push_back(mk(3'd7, 8'h80, 8'h00, 8'h00));
        exp_q.push_back(mk(3'd3, 8'h00, 8'h00, 8'h08));
        drain("opposite_hold", 400);
        total++;
        if ({current_level, ifc.active_out_down_levels} !== {3'd3, 8'h00}) begin
            bad++;
            $display("FAIL opposite_served lvl=%0d down=%h required lvl=3 down=00",
                     current_level, ifc.active_out_down_levels);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        ifc.active_in_levels       = 8'h00;
        ifc.active_out_up_levels   = 8'h00;
        ifc.active_out_down_levels = 8'h00;
        test_reset();
        test_single_trip();
        test_sweep_up();
        test_reverse();
        test_door_extend();
        test_opposite_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
